// File: rtl/signed_add_rr_pkg.sv
// rtl/signed_add_rr_pkg.sv - shared constants and signed add/saturate helpers
package signed_add_rr_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;
    localparam int W_MAX     = 32;

    // Signed add of the low w bits of a and b; returns {overflow, sum}.
    // Bits at and above w in the sum are don't-care for the caller.
    function automatic logic [W_MAX:0] sadd_ovf(
        input logic [W_MAX-1:0] a,
        input logic [W_MAX-1:0] b,
        input int               w
    );
        logic [W_MAX-1:0] s;
        s = a + b;
        return {(a[w-1] == b[w-1]) && (s[w-1] != a[w-1]), s};
    endfunction

    // Clamp value for a w-bit two's complement result of the given sign.
    function automatic logic [W_MAX-1:0] sat_value(
        input logic sign,
        input int   w
    );
        if (sign) begin
            return {W_MAX{1'b1}} << (w - 1);
        end
        return ({{(W_MAX-1){1'b0}}, 1'b1} << (w - 1)) - W_MAX'(1);
    endfunction

endpackage

// File: rtl/signed_add_rr_server_rr_arbiter.sv
// rtl/signed_add_rr_server_rr_arbiter.sv - round-robin arbiter with rotating priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req,
    input  logic                 i_adv,
    input  logic [$clog2(N)-1:0] i_idx,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_sel;
    logic          w_found;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_sel   = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    // One-hot grant from the selected index.
    always_comb begin
        o_grant = '0;
        if (w_found) begin
            o_grant[w_sel] = 1'b1;
        end
    end

    assign o_idx = w_sel;

    // Pointer moves just past the requester that was served.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= IW'((int'(i_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/signed_add_rr_server.sv
// rtl/signed_add_rr_server.sv - shared signed adder served round-robin; SIGNED_ADD_SATURATE_EN clamps on overflow
module signed_add_rr_server
    import signed_add_rr_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_sum,
    output logic               out_overflow,
    output logic [ID_W-1:0]    out_id
);

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_can_accept;
    logic             w_fire;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_wrap_sum;
    logic [W-1:0]     w_sum;
    logic             w_ovf;

    logic             r_out_valid;
    logic [W-1:0]     r_sum;
    logic             r_ovf;
    logic [ID_W-1:0]  r_id;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req_valid),
        .i_adv   (w_fire),
        .i_idx   (w_idx),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // The output register can take a new result when empty or draining now.
    assign w_can_accept = !r_out_valid || out_ready;
    assign req_ready    = w_grant & {N_REQ{w_can_accept}};
    assign w_fire       = (|w_grant) && w_can_accept;

    assign w_a        = req_a[int'(w_idx)*W +: W];
    assign w_b        = req_b[int'(w_idx)*W +: W];
    assign w_wrap_sum = W'(sadd_ovf(W_MAX'(w_a), W_MAX'(w_b), W));
    assign w_ovf      = 1'(sadd_ovf(W_MAX'(w_a), W_MAX'(w_b), W) >> W_MAX);

`ifdef SIGNED_ADD_SATURATE_EN
    assign w_sum = w_ovf ? W'(sat_value(w_a[W-1], W)) : w_wrap_sum;
`else
    assign w_sum = w_wrap_sum;
`endif

    // Result register: load on transfer, otherwise empty on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_id        <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_sum;
            r_ovf       <= w_ovf;
            r_id        <= w_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_sum      = r_sum;
    assign out_overflow = r_ovf;
    assign out_id       = r_id;

endmodule

// File: tb/tb_signed_add_rr_server.sv
// tb/tb_signed_add_rr_server.sv - directed self-checking bench for signed_add_rr_server
module tb_signed_add_rr_server;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_sum;
    logic        out_overflow;
    logic [1:0]  out_id;

    int n_tests = 0;
    int n_fail  = 0;

    signed_add_rr_server dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_id       (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

`ifdef SIGNED_ADD_SATURATE_EN
    localparam logic [3:0] E_SUM0 = 4'h7;
    localparam logic [3:0] E_SUM1 = 4'h8;
`else
    localparam logic [3:0] E_SUM0 = 4'hB;
    localparam logic [3:0] E_SUM1 = 4'h5;
`endif

    logic [1:0] exp_id  [5];
    logic [3:0] exp_sum [4];
    logic       exp_ovf [4];

    initial begin
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_sum = '{E_SUM0, E_SUM1, 4'h8, 4'h0};
        exp_ovf = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Reset with every requester valid: (4,7) (-4,-7) (-3,-5) (1,-1)
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_a     = 16'h1DC4;
        req_b     = 16'hFB97;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", req_ready, 4'b0001);
        chk("rst_sum", out_sum, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_id", out_id, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_grant", req_ready, 4'b0001);

        // Round robin, one result per cycle
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("rr_valid%0d", c), out_valid, 1);
            chk($sformatf("rr_id%0d", c), out_id, exp_id[c]);
            chk($sformatf("rr_sum%0d", c), out_sum, exp_sum[exp_id[c]]);
            chk($sformatf("rr_ovf%0d", c), out_overflow, exp_ovf[exp_id[c]]);
            if (c < 4) chk($sformatf("rr_ready%0d", c), req_ready, 4'b0001 << ((c + 1) % 4));
        end

        // Backpressure for three cycles holding id 0
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_ready%0d", c), req_ready, 4'b0000);
            chk($sformatf("bp_id%0d", c), out_id, 0);
            chk($sformatf("bp_sum%0d", c), out_sum, E_SUM0);
            chk($sformatf("bp_valid%0d", c), out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0010);
        step();
        chk("bp_after_id", out_id, 1);
        chk("bp_after_sum", out_sum, E_SUM1);

        // Drain with no requests: values hold, valid drops
        req_valid = 4'b0000;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_id", out_id, 1);
        chk("drain_sum", out_sum, E_SUM1);
        chk("drain_ovf", out_overflow, 1);

        // Single requester 2: 3 + -5 = -2
        req_a     = 16'h0300;
        req_b     = 16'h0B00;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        step();
        chk("single_valid", out_valid, 1);
        chk("single_sum", out_sum, 4'hE);
        chk("single_ovf", out_overflow, 0);
        chk("single_id", out_id, 2);

        // Requester 3: -4 + -4 = -8, no overflow
        req_a     = 16'hC000;
        req_b     = 16'hC000;
        req_valid = 4'b1000;
        step();
        chk("neg8_sum", out_sum, 4'h8);
        chk("neg8_ovf", out_overflow, 0);
        chk("neg8_id", out_id, 3);

        // Transfer from requester 0, then asynchronous reset
        req_a     = 16'h0004;
        req_b     = 16'h0007;
        req_valid = 4'b0001;
        step();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_id", out_id, 0);
        req_valid = 4'b1111;
        rst       = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", out_sum, 0);
        chk("async_rst_ptr", req_ready, 4'b0001);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_id", out_id, 0);
        chk("post_rst_valid", out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
